// File: rtl/bg_ram_sched_if.sv
// -----------------------------------------------------------------------------
// bg_ram_sched_if
// Bundle of every non-clock signal around the background RAM scheduler.
//   master : the environment (VGA sync generator, game-logic writer, RAM)
//   slave  : the scheduler itself
// Signal groups:
//   video  : pix_x, pix_y, video_on, frame_start, scroll      (master -> slave)
//   writer : wr_req, wr_addr, wr_data                         (master -> slave)
//            wr_ack, wr_err                                   (slave -> master)
//   ram    : ram_a, ram_d, ram_we                             (slave -> master)
//            ram_spo (asynchronous read data)                 (master -> slave)
//   pixel  : pix_data, pix_valid                              (slave -> master)
// -----------------------------------------------------------------------------
interface bg_ram_sched_if;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        video_on;
  logic        frame_start;
  logic [7:0]  scroll;

  logic        wr_req;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        wr_err;

  logic [14:0] ram_a;
  logic [15:0] ram_d;
  logic        ram_we;
  logic [15:0] ram_spo;

  logic [15:0] pix_data;
  logic        pix_valid;

  modport master (
    output pix_x, pix_y, video_on, frame_start, scroll,
    output wr_req, wr_addr, wr_data,
    input  wr_ack, wr_err,
    input  ram_a, ram_d, ram_we,
    output ram_spo,
    input  pix_data, pix_valid
  );

  modport slave (
    input  pix_x, pix_y, video_on, frame_start, scroll,
    input  wr_req, wr_addr, wr_data,
    output wr_ack, wr_err,
    output ram_a, ram_d, ram_we,
    input  ram_spo,
    output pix_data, pix_valid
  );
endinterface

// File: rtl/bg_ram_sched.sv
// -----------------------------------------------------------------------------
// bg_ram_sched
// Owns the single port of the BG_W x BG_H background RAM and shares it between
// the VGA scan reader (4x upscale plus horizontal scroll, absolute priority in
// active video) and a background writer that only gets slots while blank.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : bg_ram_sched_if.slave (video timing, writer handshake, RAM port,
//          pixel output)
// Read path: inputs at cycle n -> ram_a at n+1 -> pix_data/pix_valid at n+2.
//
// Writer FSM
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | reader owns ram_a; grant on wr_req while blank and no frame_start
//   ST_WRITE | ram_a/ram_d show the captured request; ram_we if address in range
//   ST_ACK   | wr_ack pulse; reader owns ram_a again
// -----------------------------------------------------------------------------
module bg_ram_sched #(
  parameter int BG_W     = 160,
  parameter int BG_H     = 120,
  parameter int SCALE_SH = 2
) (
  input  logic           clk,
  input  logic           rst,
  bg_ram_sched_if.slave  bus
);

  localparam logic [8:0]  BG_W_9  = 9'(BG_W);
  localparam logic [10:0] BG_W_11 = 11'(BG_W);
  localparam logic [14:0] NTEX_15 = 15'(BG_W * BG_H);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [7:0]  scroll_q,    scroll_d;
  logic [14:0] rd_addr_q,   rd_addr_d;
  logic        v1_q,        v1_d;
  logic [15:0] pix_data_q,  pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic [1:0]  state_q,     state_d;
  logic [14:0] wa_q,        wa_d;
  logic [15:0] wd_q,        wd_d;
  logic        wok_q,       wok_d;
  logic        err_q,       err_d;

  logic [9:0]  tex_x;
  logic [8:0]  tex_y;
  logic [10:0] bx_sum;
  logic [10:0] bx;
  logic        wr_in_range;

  // Scroll only moves on frame_start, so a frame is always drawn with a single
  // offset; out-of-range requests keep the previous value.
  always_comb begin
    scroll_d = scroll_q;
    if (bus.frame_start && ({1'b0, bus.scroll} < BG_W_9)) begin
      scroll_d = bus.scroll;
    end
  end

  // Texel address of the current pixel. bx_sum is at most 159 + 159 for legal
  // pix_x, so one conditional subtract is enough for the wrap.
  always_comb begin
    tex_x     = bus.pix_x >> SCALE_SH;
    tex_y     = bus.pix_y >> SCALE_SH;
    bx_sum    = {1'b0, tex_x} + {3'b000, scroll_q};
    bx        = (bx_sum >= BG_W_11) ? (bx_sum - BG_W_11) : bx_sum;
    rd_addr_d = (15'(tex_y) * 15'(BG_W)) + 15'(bx);
  end

  // Pixel pipeline: pix_data is forced to zero outside the active area so a
  // slot displaced by a write can never leak the write address contents.
  always_comb begin
    v1_d        = bus.video_on;
    pix_valid_d = v1_q;
    pix_data_d  = v1_q ? bus.ram_spo : 16'h0000;
  end

  assign wr_in_range = (bus.wr_addr < NTEX_15);

  // Writer FSM. frame_start blocks a grant so the scroll update and a write
  // never share a cycle. wr_err is raised at grant, so it is already visible
  // during WRITE and stays set until reset.
  always_comb begin
    state_d = state_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    wok_d   = wok_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.wr_req && !bus.video_on && !bus.frame_start) begin
          state_d = ST_WRITE;
          wa_d    = bus.wr_addr;
          wd_d    = bus.wr_data;
          wok_d   = wr_in_range;
          if (!wr_in_range) begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_q    <= '0;
      rd_addr_q   <= '0;
      v1_q        <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      state_q     <= ST_IDLE;
      wa_q        <= '0;
      wd_q        <= '0;
      wok_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      scroll_q    <= scroll_d;
      rd_addr_q   <= rd_addr_d;
      v1_q        <= v1_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      state_q     <= state_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      wok_q       <= wok_d;
      err_q       <= err_d;
    end
  end

  // RAM port outputs decode straight from state so that an asynchronous reset
  // drops ram_we in the same cycle instead of one edge later.
  assign bus.ram_a     = (state_q == ST_WRITE) ? wa_q : rd_addr_q;
  assign bus.ram_d     = wd_q;
  assign bus.ram_we    = (state_q == ST_WRITE) && wok_q;
  assign bus.wr_ack    = (state_q == ST_ACK);
  assign bus.wr_err    = err_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.pix_valid = pix_valid_q;

endmodule
